// File: rtl/mac_unit.sv
// Output-stationary systolic-array processing element: forwards A/B operands
// one cycle later and accumulates their unsigned product into out_sum.
module mac_unit #(
    parameter int data_size = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [data_size-1:0]   in_a,
    input  logic [data_size-1:0]   in_b,
    output logic [data_size-1:0]   out_a,
    output logic [data_size-1:0]   out_b,
    output logic [2*data_size-1:0] out_sum
);

    localparam int AccW = 2 * data_size;

    logic [data_size-1:0] a_q, a_d;
    logic [data_size-1:0] b_q, b_d;
    logic [AccW-1:0]      sum_q, sum_d;
    logic [AccW-1:0]      prod;

    // Operands are zero-extended so the product is computed at full width;
    // the accumulate then wraps modulo 2^AccW with no saturation.
    always_comb begin
        prod  = {{data_size{1'b0}}, in_a} * {{data_size{1'b0}}, in_b};
        a_d   = in_a;
        b_d   = in_b;
        sum_d = sum_q + prod;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
        end
    end

    assign out_a   = a_q;
    assign out_b   = b_q;
    assign out_sum = sum_q;

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit: a plain-arithmetic reference model checked every
// cycle, plus literal expectations taken from hand-computed vectors.
module tb_mac_unit;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [W-1:0]   out_a;
    logic [W-1:0]   out_b;
    logic [2*W-1:0] out_sum;

    int total = 0;
    int bad   = 0;

    longint m_a, m_b, m_sum;
    bit     m_valid = 1'b0;

    mac_unit #(.data_size(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_a    (in_a),
        .in_b    (in_b),
        .out_a   (out_a),
        .out_b   (out_b),
        .out_sum (out_sum)
    );

    always #5 clk = ~clk;

    // Reference model: what each register must hold after the edge.
    always @(posedge clk) begin
        if (reset) begin
            m_a     = 0;
            m_b     = 0;
            m_sum   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_a   = longint'(in_a);
            m_b   = longint'(in_b);
            m_sum = (m_sum + longint'(in_a) * longint'(in_b)) % 65536;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input longint exp);
        total++;
        if (got !== exp[31:0]) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_a",   {24'd0, out_a},   m_a);
            chk("model_b",   {24'd0, out_b},   m_b);
            chk("model_sum", {16'd0, out_sum}, m_sum);
        end
    end

    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        reset = r;
        in_a  = a;
        in_b  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input longint ea, input longint eb, input longint es);
        chk({name, "_a"},   {24'd0, out_a},   ea);
        chk({name, "_b"},   {24'd0, out_b},   eb);
        chk({name, "_sum"}, {16'd0, out_sum}, es);
    endtask

    longint seq_exp [10] = '{0, 2, 8, 20, 40, 70, 112, 168, 240, 330};

    initial begin
        // Reset ignores operands
        step(1'b1, 8'd5, 8'd7);
        chk_all("reset", 0, 0, 0);

        // Single MAC
        step(1'b0, 8'd3, 8'd4);
        chk_all("single", 3, 4, 12);

        // Accumulation sequence
        step(1'b1, 8'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, W'(i), W'(i + 1));
            chk_all($sformatf("seq%0d", i), i, i + 1, seq_exp[i]);
        end

        // Wrap-around
        step(1'b1, 8'd0, 8'd0);
        step(1'b0, 8'd255, 8'd255);
        chk("wrap1_sum", {16'd0, out_sum}, 65025);
        step(1'b0, 8'd255, 8'd255);
        chk("wrap2_sum", {16'd0, out_sum}, 64514);

        // Reset mid-accumulation
        step(1'b1, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b0, W'(i), W'(i + 1));
        chk("mid_pre_sum", {16'd0, out_sum}, 40);
        step(1'b1, 8'd9, 8'd9);
        chk_all("mid_reset", 0, 0, 0);
        step(1'b0, 8'd2, 8'd6);
        chk_all("mid_after", 2, 6, 12);

        // Zero operand holds the sum
        step(1'b1, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b0, W'(i), W'(i + 1));
        chk("zero_pre_sum", {16'd0, out_sum}, 20);
        step(1'b0, 8'd0, 8'd9);
        chk_all("zero_op", 0, 9, 20);
        step(1'b0, 8'd0, 8'd0);
        chk_all("idle", 0, 0, 20);

        // Mixed vectors with occasional reset, checked by the model each cycle
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 15) == 0), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 8'd200 + W'(i), 8'd250);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
